ascon_perm_core: RTL and testbench
==================================

Name: ascon_perm_core

Overview:
- Parametrised successor to the single-config Ascon core: 320-bit state (five 64-bit words) with word-addressed load/XOR/read access.
- Runs the Ascon permutation p^n for any n in 1..12 (SP 800-232 constant schedule), UNROLL rounds per clock.
- Sits between the mode controllers (AEAD/hash/XOF) and the datapath; the controller loads words, starts, and waits for ready.

Parameters:
- UNROLL, 1, rounds per clock; legal 1..4, elaboration error otherwise.
- WORD_W, 64, word width; fixed at 64, elaboration error otherwise (kept for package consistency).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- start_perm_i  in  1  start permutation (sampled in IDLE only)
- rounds_i  in  4  round count n for this start, legal 1..12
- word_sel_i  in  3  word address 0..4
- data_i  in  64  write/XOR data
- write_en_i  in  1  state[word_sel_i] <= data_i
- xor_en_i  in  1  state[word_sel_i] ^= data_i
- data_o  out  64  state[word_sel_i], combinational
- ready_o  out  1  1 = IDLE, core accepts access/start
- done_o  out  1  one-cycle pulse on the last permutation cycle's following edge

Behaviour:
- Reset (rst=0 at posedge): all 5 words = 0, FSM=IDLE, remaining=0, ready_o=1, done_o=0. Reset mid-RUN aborts; state is cleared.
- FSM states: IDLE, RUN.
- IDLE:
  - write_en_i has priority over xor_en_i when both are asserted.
  - word_sel_i 5..7: writes/XORs ignored, data_o=0.
  - start_perm_i=1 with rounds_i in 1..12 -> latch round index r = 12-n, remaining = n, go to RUN, ready_o=0 next cycle.
  - start_perm_i with rounds_i 0 or 13..15 is ignored; stay IDLE, no done_o.
  - Start together with write/xor in the same cycle: the access is applied first; the permutation starts next cycle from the updated state.
- RUN:
  - Each cycle apply k = min(UNROLL, remaining) rounds: r += k, remaining -= k.
  - Writes, XORs and start are ignored; data_o shows the intermediate state.
  - When remaining reaches 0 -> IDLE, ready_o=1 and done_o=1 for exactly one cycle.
  - Latency from the start edge to ready_o=1 is ceil(n/UNROLL) cycles.
- Round i (constant index r): pc: x2 ^= C[r], where C = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B (zero-extended); ps: 5-bit Ascon S-box bit-sliced; pl: x0^=ror19^ror28, x1^=ror61^ror39, x2^=ror1^ror6, x3^=ror10^ror17, x4^=ror7^ror41.
- Partial last cycle (n not a multiple of UNROLL): unused unrolled stages are bypassed; the result is bit-exact with UNROLL=1.
- Word order: x0 = word 0. Bit/byte ordering matches ascon_pkg (little-endian 64-bit words per SP 800-232).

Optional Feature:
- Macro ASCON_PERM_PERF_EN.
- Defined: adds output perm_count_o [31:0], cleared by reset, incremented on each done_o, wraps at 2^32-1 -> 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle: ready_o=1, done_o=0, data_o=0 for word_sel 0..7.
- Write 0x0123456789ABCDEF to word 2, then XOR 0xFFFFFFFFFFFFFFFF to word 2 -> data_o=0xFEDCBA9876543210. Both enables with data 0x1 -> word = 0x1. Write to word 6 -> words 0..4 unchanged.
- UNROLL=1, load the Ascon-Hash256 IV into x0 with the rest zero, start n=12 -> ready_o low 12 cycles, done_o single pulse, 5 words bit-exact vs C reference model.
- UNROLL=3, same load, n=8 -> 3 cycles (3+3+2), result identical to the UNROLL=1 n=8 run. UNROLL=4, n=6 -> 2 cycles.
- start with rounds_i=0 and 13 -> no state change, ready_o stays 1. start_perm_i and write_en_i pulsed during RUN -> ignored, final result unchanged.
- rst=0 on the 2nd cycle of an n=12 run -> next cycle all words 0, ready_o=1, no done_o. With ASCON_PERM_PERF_EN, 3 runs -> perm_count_o=3; reset -> 0.

Source files
------------

// File: rtl/ascon_perm_core.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_perm_core
//  Description : Ascon p^n permutation core (n = 1..12) with a word-addressed
//                320-bit state (x0 = word 0). Runs UNROLL rounds per clock;
//                unused stages in a partial last cycle are bypassed.
//                Optional macro ASCON_PERM_PERF_EN adds perm_count_o, a
//                32-bit count of completed permutations.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_perm_core #(
    parameter int UNROLL = 1,
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_perm_i,
    input  logic [3:0]        rounds_i,
    input  logic [2:0]        word_sel_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              write_en_i,
    input  logic              xor_en_i,
    output logic [WORD_W-1:0] data_o,
    output logic              ready_o,
    output logic              done_o
`ifdef ASCON_PERM_PERF_EN
    ,
    output logic [31:0]       perm_count_o
`endif
);

    if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
        $error("ascon_perm_core: UNROLL must be in 1..4");
    end
    if (WORD_W != 64) begin : g_bad_word_w
        $error("ascon_perm_core: WORD_W must be 64");
    end

    typedef logic [4:0][63:0] st_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_e;

    fsm_e       fsm_q, fsm_d;
    st_t        state_q, state_d;
    logic [3:0] ridx_q, ridx_d;
    logic [3:0] rem_q, rem_d;
    logic       done_q, done_d;
    st_t        perm_next;
    logic [3:0] step;
    logic       rounds_ok;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full Ascon round: constant addition, bit-sliced S-box, linear layer.
    function automatic st_t round_f(input st_t s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        st_t         o;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        // Round constant byte is {15-r, r}.
        x2 = x2 ^ {56'd0, ~r, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return o;
    endfunction

    // Unrolled round chain; stages beyond the remaining count pass through.
    always_comb begin
        st_t s;
        s = state_q;
        for (int j = 0; j < UNROLL; j++) begin
            if (4'(j) < rem_q) begin
                s = round_f(s, ridx_q + 4'(j));
            end
        end
        perm_next = s;
        step      = (rem_q > 4'(UNROLL)) ? 4'(UNROLL) : rem_q;
        rounds_ok = (rounds_i != 4'd0) && (rounds_i <= 4'd12);
    end

    // Next-state logic: word access and start in IDLE, round progress in RUN.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        ridx_d  = ridx_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                for (int w = 0; w < 5; w++) begin
                    if (word_sel_i == 3'(w)) begin
                        if (write_en_i) begin
                            state_d[w] = data_i;
                        end else if (xor_en_i) begin
                            state_d[w] = state_q[w] ^ data_i;
                        end
                    end
                end
                if (start_perm_i && rounds_ok) begin
                    fsm_d  = ST_RUN;
                    ridx_d = 4'd12 - rounds_i;
                    rem_d  = rounds_i;
                end
            end
            ST_RUN: begin
                state_d = perm_next;
                ridx_d  = ridx_q + step;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    fsm_d  = ST_IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            ridx_q  <= 4'd0;
            rem_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            ridx_q  <= ridx_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Combinational word read; unmapped addresses read as zero.
    always_comb begin
        data_o = '0;
        for (int w = 0; w < 5; w++) begin
            if (word_sel_i == 3'(w)) begin
                data_o = state_q[w];
            end
        end
    end

    assign ready_o = (fsm_q == ST_IDLE);
    assign done_o  = done_q;

`ifdef ASCON_PERM_PERF_EN
    logic [31:0] perm_count_q, perm_count_d;

    // Completed-permutation counter, wraps naturally at 2^32.
    always_comb begin
        perm_count_d = perm_count_q + {31'd0, done_d};
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perm_count_q <= 32'd0;
        end else begin
            perm_count_q <= perm_count_d;
        end
    end

    assign perm_count_o = perm_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascon_perm_core
//  Description : Self-checking bench for ascon_perm_core; three instances
//                with UNROLL = 1, 3, 4 against a table-based Ascon model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_perm_core;

    typedef logic [4:0][63:0] st_t;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0] RC [12] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    localparam logic [63:0] IV = 64'h0000080100CC0002;
    localparam int UNR [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst_n  [3];
    logic        start  [3];
    logic [3:0]  rounds [3];
    logic [2:0]  sel    [3];
    logic [63:0] din    [3];
    logic        we     [3];
    logic        xe     [3];
    logic [63:0] dout   [3];
    logic        ready  [3];
    logic        done   [3];
`ifdef ASCON_PERM_PERF_EN
    logic [31:0] pcount [3];
`endif

    st_t mdl  [3];
    int  runs [3];
    int  checks = 0;
    int  errors = 0;

    always #10 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_perm_core #(.UNROLL(UNR[g]), .WORD_W(64)) u_dut (
            .clk          (clk),
            .rst          (rst_n[g]),
            .start_perm_i (start[g]),
            .rounds_i     (rounds[g]),
            .word_sel_i   (sel[g]),
            .data_i       (din[g]),
            .write_en_i   (we[g]),
            .xor_en_i     (xe[g]),
            .data_o       (dout[g]),
            .ready_o      (ready[g]),
            .done_o       (done[g])
`ifdef ASCON_PERM_PERF_EN
            ,
            .perm_count_o (pcount[g])
`endif
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x};
        return d[n +: 64];
    endfunction

    function automatic st_t model_perm(input st_t s, input int n);
        st_t x, y;
        logic [4:0] v, o;
        x = s;
        for (int r = 12 - n; r < 12; r++) begin
            x[2] = x[2] ^ {56'd0, RC[r]};
            for (int b = 0; b < 64; b++) begin
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[v];
                y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2];
                y[3][b] = o[1]; y[4][b] = o[0];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return x;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input int k, input logic [2:0] s, output logic [63:0] v);
        sel[k] = s;
        #1;
        v = dout[k];
    endtask

    task automatic chk_state(input int k, input string nm);
        logic [63:0] v;
        for (int w = 0; w < 5; w++) begin
            rd(k, 3'(w), v);
            chk($sformatf("%s_u%0d_w%0d", nm, UNR[k], w), v, mdl[k][w]);
        end
    endtask

    task automatic access(input int k, input logic w, input logic x,
                          input logic [2:0] s, input logic [63:0] d);
        we[k] = w; xe[k] = x; sel[k] = s; din[k] = d;
        tick();
        we[k] = 1'b0; xe[k] = 1'b0;
        if (s < 3'd5) begin
            if (w)      mdl[k][s] = d;
            else if (x) mdl[k][s] = mdl[k][s] ^ d;
        end
    endtask

    task automatic load_state(input int k, input st_t s);
        for (int w = 0; w < 5; w++) access(k, 1'b1, 1'b0, 3'(w), s[w]);
    endtask

    task automatic run_perm(input int k, input int n, input bit interfere,
                            input bit pre_wr, input logic [2:0] pre_sel,
                            input logic [63:0] pre_data);
        int cyc, dcnt, exp_lat;
        string tag;
        tag = $sformatf("u%0d_n%0d", UNR[k], n);
        exp_lat = (n + UNR[k] - 1) / UNR[k];
        if (pre_wr) begin
            we[k] = 1'b1; sel[k] = pre_sel; din[k] = pre_data;
            if (pre_sel < 3'd5) mdl[k][pre_sel] = pre_data;
        end
        start[k] = 1'b1; rounds[k] = 4'(n);
        tick();
        start[k] = 1'b0; we[k] = 1'b0;
        chk({"ready_low_", tag}, {63'd0, ready[k]}, 64'd0);
        mdl[k] = model_perm(mdl[k], n);
        if (interfere) begin
            start[k] = 1'b1; rounds[k] = 4'd5; we[k] = 1'b1; xe[k] = 1'b1;
            sel[k] = 3'd0; din[k] = '1;
        end
        cyc = 0; dcnt = 0;
        while (ready[k] !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            start[k] = 1'b0; we[k] = 1'b0; xe[k] = 1'b0;
            if (done[k] === 1'b1) dcnt++;
        end
        chk({"latency_", tag}, 64'(cyc), 64'(exp_lat));
        chk({"done_at_end_", tag}, {63'd0, done[k]}, 64'd1);
        chk({"done_count_", tag}, 64'(dcnt), 64'd1);
        tick();
        chk({"done_single_", tag}, {63'd0, done[k]}, 64'd0);
        runs[k]++;
        chk_state(k, {"perm_", tag});
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic        x;
        logic [2:0]  s;
        logic [63:0] d;
        logic [2:0]  rsel;
        logic [63:0] exp;
    } acc_vec_t;

    // ---------------- main sequence ----------------
    initial begin
        acc_vec_t vt [9];
        logic [63:0] v;
        st_t rs;
        int k, n;

        vt[0] = '{"wr_w2",    1'b1, 1'b0, 3'd2, 64'h0123456789ABCDEF, 3'd2, 64'h0123456789ABCDEF};
        vt[1] = '{"xor_w2",   1'b0, 1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFF, 3'd2, 64'hFEDCBA9876543210};
        vt[2] = '{"wr_w1",    1'b1, 1'b0, 3'd1, 64'h1,                3'd1, 64'h1};
        vt[3] = '{"both_w1",  1'b1, 1'b1, 3'd1, 64'h1,                3'd1, 64'h1};
        vt[4] = '{"xor_w4",   1'b0, 1'b1, 3'd4, 64'hA5A5A5A5A5A5A5A5, 3'd4, 64'hA5A5A5A5A5A5A5A5};
        vt[5] = '{"wr_w6",    1'b1, 1'b0, 3'd6, 64'hDEADBEEF,         3'd6, 64'h0};
        vt[6] = '{"xor_w7",   1'b0, 1'b1, 3'd7, 64'hFF,               3'd7, 64'h0};
        vt[7] = '{"wr_w5",    1'b1, 1'b0, 3'd5, 64'h123,              3'd2, 64'hFEDCBA9876543210};
        vt[8] = '{"wr_w0",    1'b1, 1'b0, 3'd0, 64'hCAFEF00D12345678, 3'd0, 64'hCAFEF00D12345678};

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; rounds[i] = 4'd0; sel[i] = 3'd0;
            din[i] = '0; we[i] = 1'b0; xe[i] = 1'b0; mdl[i] = '0; runs[i] = 0;
        end
        tick(); tick();
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        tick();

        // Reset state on every instance.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready_u%0d", UNR[i]), {63'd0, ready[i]}, 64'd1);
            chk($sformatf("rst_done_u%0d", UNR[i]), {63'd0, done[i]}, 64'd0);
            for (int s = 0; s < 8; s++) begin
                rd(i, 3'(s), v);
                chk($sformatf("rst_data_u%0d_s%0d", UNR[i], s), v, 64'd0);
            end
        end

        // Word access table on the UNROLL=1 instance.
        for (int i = 0; i < 9; i++) begin
            access(0, vt[i].w, vt[i].x, vt[i].s, vt[i].d);
            rd(0, vt[i].rsel, v);
            chk(vt[i].name, v, vt[i].exp);
        end
        chk_state(0, "access");

        // Illegal round counts are ignored.
        foreach (RC[j]) begin
            if (j < 3) begin
                start[0] = 1'b1;
                rounds[0] = (j == 0) ? 4'd0 : ((j == 1) ? 4'd13 : 4'd15);
                tick();
                start[0] = 1'b0;
                chk($sformatf("bad_rounds_ready_%0d", rounds[0]), {63'd0, ready[0]}, 64'd1);
                tick();
                chk($sformatf("bad_rounds_done_%0d", rounds[0]), {63'd0, done[0]}, 64'd0);
            end
        end
        chk_state(0, "bad_rounds");

        // Hash IV runs on each unroll setting.
        rs = '0; rs[0] = IV;
        load_state(0, rs); run_perm(0, 12, 1'b0, 1'b0, 3'd0, 64'd0);
        load_state(1, rs); run_perm(1, 8,  1'b0, 1'b0, 3'd0, 64'd0);
        load_state(0, rs); run_perm(0, 8,  1'b0, 1'b0, 3'd0, 64'd0);
        load_state(2, rs); run_perm(2, 6,  1'b0, 1'b0, 3'd0, 64'd0);

        // Access in the same cycle as start lands before the permutation.
        run_perm(1, 4, 1'b0, 1'b1, 3'd3, 64'h0F1E2D3C4B5A6978);

        // Start / write / xor during RUN are ignored.
        load_state(0, rs); run_perm(0, 12, 1'b1, 1'b0, 3'd0, 64'd0);
        load_state(2, rs); run_perm(2, 12, 1'b1, 1'b0, 3'd0, 64'd0);

        // Reset on the 2nd cycle of an n=12 run aborts it.
        load_state(0, rs);
        start[0] = 1'b1; rounds[0] = 4'd12;
        tick();
        start[0] = 1'b0;
        tick();
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        mdl[0] = '0; runs[0] = 0;
        chk("abort_ready", {63'd0, ready[0]}, 64'd1);
        chk("abort_done", {63'd0, done[0]}, 64'd0);
        chk_state(0, "abort");
        tick();
        chk("abort_done_late", {63'd0, done[0]}, 64'd0);

        // Randomised runs against the model.
        for (int it = 0; it < 24; it++) begin
            k = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 12));
            for (int w = 0; w < 5; w++) rs[w] = {$urandom, $urandom};
            load_state(k, rs);
            if ((it % 4) == 3)
                run_perm(k, n, 1'b0, 1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom});
            else
                run_perm(k, n, 1'b0, 1'b0, 3'd0, 64'd0);
        end

`ifdef ASCON_PERM_PERF_EN
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("perf_count_u%0d", UNR[i]), {32'd0, pcount[i]}, 64'(runs[i]));
            rst_n[i] = 1'b0;
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b1;
            chk($sformatf("perf_reset_u%0d", UNR[i]), {32'd0, pcount[i]}, 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
